// File: rtl/display_scan_ctrl.sv
// Multiplexed four-digit seven-segment scan controller.
// Walks the four digit slots at DIV clk cycles per slot, presents the active
// BCD nibble to the shared decoder, and double-buffers new display values so
// that the visible digits only change on a frame boundary.
module display_scan_ctrl #(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data,
  input  logic        lzb_en,
  output logic        ready,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        blank,
  output logic        frame_done
);

  // DIV=1 would give a zero-width counter; keep one bit so tick is constant high.
  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          tick;
  logic          frame_bnd;
  logic [15:0]   disp;
  logic [15:0]   pend;
  logic          pend_valid;
  logic [3:0]    zero_above;

  assign tick      = (cnt == CNT_MAX);
  assign frame_bnd = tick && (idx == 2'd3);
  assign ready     = ~pend_valid;

  // Slot prescaler: counts 0..DIV-1 and wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

  // Active slot index, advances once per slot period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       idx <= 2'd0;
    else if (tick) idx <= idx + 2'd1;
  end

  // End-of-frame pulse, registered one cycle after the last slot's tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_done <= 1'b0;
    else     frame_done <= frame_bnd;
  end

  // Double buffer: pending value moves to the display only at a frame boundary.
  // A load coinciding with a transfer is dropped because pend is still full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp       <= 16'h0000;
      pend       <= 16'h0000;
      pend_valid <= 1'b0;
    end else if (frame_bnd && pend_valid) begin
      disp       <= pend;
      pend_valid <= 1'b0;
    end else if (load && !pend_valid) begin
      pend       <= data;
      pend_valid <= 1'b1;
    end
  end

  // Slot decode: nibble select, blanking (invalid BCD or leading zero), digit enables.
  always_comb begin
    zero_above    = 4'b0000;
    zero_above[3] = (disp[15:12] == 4'h0);
    zero_above[2] = zero_above[3] && (disp[11:8] == 4'h0);
    zero_above[1] = zero_above[2] && (disp[7:4] == 4'h0);
    // Slot 0 always shows, so a zero value still displays a single 0.
    zero_above[0] = 1'b0;

    digit = disp[{idx, 2'b00} +: 4];
    blank = (digit > 4'd9) || (lzb_en && zero_above[idx]);
    if (blank) an = 4'b1111;
    else       an = ~(4'b0001 << idx);
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with DIV=4.
// Stimulus pushes hand-computed per-cycle expectations tagged with a cycle
// number; the monitor pops and compares them on the falling edge.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = 16'h0000;
  logic        lzb_en = 1'b0;
  logic        ready;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        blank;
  logic        frame_done;

  display_scan_ctrl #(.DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data       (data),
    .lzb_en     (lzb_en),
    .ready      (ready),
    .digit      (digit),
    .an         (an),
    .blank      (blank),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [3:0] dg;
    logic       bl;
    logic       rdy;
    logic       fd;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   rel = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic flush = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation due at this cycle.
  initial forever begin
    @(negedge clk);
    if (flush) begin
      while (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        n_vec++;
        n_bad++;
        $display("FAIL %s timeout: expectation for cyc %0d never reached, now cyc %0d", mon_e.tag, mon_e.cyc, cyc);
      end
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if (mon_e.cyc != cyc ||
          {an, digit, blank, ready, frame_done} !==
          {mon_e.an, mon_e.dg, mon_e.bl, mon_e.rdy, mon_e.fd}) begin
        n_bad++;
        $display("FAIL %s @cyc %0d (due %0d): got an=%b digit=%h blank=%b ready=%b frame_done=%b, want an=%b digit=%h blank=%b ready=%b frame_done=%b",
                 mon_e.tag, cyc, mon_e.cyc, an, digit, blank, ready, frame_done,
                 mon_e.an, mon_e.dg, mon_e.bl, mon_e.rdy, mon_e.fd);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors applied, %0d miscompares", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input int c, input logic [3:0] a, input logic [3:0] d,
                          input logic b, input logic r, input logic f, input string t);
    exp_t e;
    e.cyc = c; e.an = a; e.dg = d; e.bl = b; e.rdy = r; e.fd = f; e.tag = t;
    exp_q.push_back(e);
  endtask

  // Expectations for cycles j0..j1 of a 16-cycle frame starting at k0 after release.
  // an_p/dg_p/bl_p hold the per-slot expected values, slot 0 in the low bits.
  task automatic push_frame(input int k0, input int j0, input int j1,
                            input logic [15:0] an_p, input logic [15:0] dg_p,
                            input logic [3:0] bl_p, input logic rdy0,
                            input logic rdy_rest, input logic fd0, input string t);
    for (int j = j0; j <= j1; j++) begin
      int s;
      s = j / 4;
      push_exp(rel + k0 + j, an_p[4*s +: 4], dg_p[4*s +: 4], bl_p[s],
               (j == 0) ? rdy0 : rdy_rest, (j == 0) ? fd0 : 1'b0, t);
    end
  endtask

  task automatic goto_k(input int k);
    while (cyc < rel + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Asserts reset just after an edge and expects the reset state in that same cycle.
  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    push_exp(cyc, 4'b1110, 4'h0, 1'b0, 1'b1, 1'b0, "rst_state");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    rel = cyc;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      flush = 1'b1;
      @(negedge clk);
      #1;
      flush = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;

    // Scan of 1234 without blanking; frame_done every 16 cycles.
    do_reset();
    lzb_en = 1'b0; load = 1'b1; data = 16'h1234;
    push_frame(0,  0, 15, 16'h7BDE, 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b0, "f0_1234");
    push_frame(16, 0, 15, 16'h7BDE, 16'h1234, 4'b0000, 1'b1, 1'b1, 1'b1, "scan_1234");
    push_frame(32, 0, 0,  16'h7BDE, 16'h1234, 4'b0000, 1'b1, 1'b1, 1'b1, "fd_32");
    goto_k(1); load = 1'b0;
    drain();

    // Back-to-back loads: second dropped; then reset with a load pending.
    do_reset();
    load = 1'b1; data = 16'h1111;
    push_frame(0,  0, 15, 16'h7BDE, 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b0, "f0_1111");
    push_frame(16, 0, 4,  16'h7BDE, 16'h1111, 4'b0000, 1'b1, 1'b1, 1'b1, "drop_2222");
    push_exp(rel + 21, 4'b1101, 4'h1, 1'b0, 1'b0, 1'b0, "pend_0050");
    goto_k(1); data = 16'h2222;
    goto_k(2); load = 1'b0;
    goto_k(20); load = 1'b1; data = 16'h0050;
    goto_k(21); load = 1'b0;
    goto_k(22);
    do_reset();
    push_frame(0,  0, 15, 16'h7BDE, 16'h0000, 4'b0000, 1'b1, 1'b1, 1'b0, "post_rst");
    push_frame(16, 0, 5,  16'h7BDE, 16'h0000, 4'b0000, 1'b1, 1'b1, 1'b1, "pend_discard");
    drain();

    // 0050 with leading-zero blanking, then blanking disabled mid-slot.
    do_reset();
    lzb_en = 1'b1; load = 1'b1; data = 16'h0050;
    push_frame(0,  0, 15, 16'hFFFE, 16'h0000, 4'b1110, 1'b1, 1'b0, 1'b0, "lzb_zero");
    push_frame(16, 0, 13, 16'hFFDE, 16'h0050, 4'b1100, 1'b1, 1'b1, 1'b1, "lzb_0050");
    push_frame(16, 14, 15, 16'h7BDE, 16'h0050, 4'b0000, 1'b1, 1'b1, 1'b1, "lzb_off_now");
    push_frame(32, 0, 15, 16'h7BDE, 16'h0050, 4'b0000, 1'b1, 1'b1, 1'b1, "nolzb_0050");
    goto_k(1); load = 1'b0;
    goto_k(30); lzb_en = 1'b0;
    drain();

    // Invalid BCD nibble blanks its slot with or without LZB.
    do_reset();
    lzb_en = 1'b0; load = 1'b1; data = 16'h00A0;
    push_frame(0,  0, 15, 16'h7BDE, 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b0, "f0_00a0");
    push_frame(16, 0, 15, 16'h7BFE, 16'h00A0, 4'b0010, 1'b1, 1'b1, 1'b1, "bad_bcd");
    push_frame(32, 0, 15, 16'hFFFE, 16'h00A0, 4'b1110, 1'b1, 1'b1, 1'b1, "bad_bcd_lzb");
    goto_k(1); load = 1'b0;
    goto_k(32); lzb_en = 1'b1;
    drain();

    // Load on boundaries: dropped when pend full, captured when pend empty.
    do_reset();
    lzb_en = 1'b0; load = 1'b1; data = 16'h1234;
    push_frame(0,  0, 15, 16'h7BDE, 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b0, "f0_bnd");
    push_frame(16, 0, 15, 16'h7BDE, 16'h1234, 4'b0000, 1'b1, 1'b1, 1'b1, "bnd_drop");
    push_frame(32, 0, 15, 16'h7BDE, 16'h1234, 4'b0000, 1'b0, 1'b0, 1'b1, "bnd_capture");
    push_frame(48, 0, 15, 16'h7BDE, 16'h9876, 4'b0000, 1'b1, 1'b1, 1'b1, "show_9876");
    goto_k(1);  load = 1'b0;
    goto_k(15); load = 1'b1; data = 16'h5678;
    goto_k(16); load = 1'b0;
    goto_k(31); load = 1'b1; data = 16'h9876;
    goto_k(32); load = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have one clock `clk` and one reset `rst`; reset is asynchronous and active-high.
REQ-002 Parameter: DIV, default 50000, meaning clk cycles per digit slot; legal range DIV >= 1.
REQ-003 Port: clk  input  1  rising-edge system clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: load  input  1  request to accept `data` this cycle.
REQ-006 Port: data  input  16  four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 Port: lzb_en  input  1  leading-zero blanking enable.
REQ-008 Port: ready  output  1  high when a load will be accepted.
REQ-009 Port: digit  output  4  BCD nibble of the active slot, driving the shared seven-segment decoder.
REQ-010 Port: an  output  4  active-low digit enables; bit i selects digit i.
REQ-011 Port: blank  output  1  high when the active slot is blanked.
REQ-012 Port: frame_done  output  1  one-cycle pulse at the end of each full 4-digit scan.

Function
REQ-013 Prescaler cnt SHALL count 0..DIV-1 and wrap to 0; tick = (cnt == DIV-1). With DIV=1, tick is high every cycle.
REQ-014 Slot index idx (2 bits) SHALL advance on tick, in the order 0,1,2,3,0; 3 wraps to 0.
REQ-015 Frame boundary = tick AND idx==3; frame_done SHALL be registered, high exactly the cycle after a frame boundary edge.
REQ-016 Storage: display register disp[15:0], pending register pend[15:0], and flag pend_valid; ready = NOT pend_valid.
REQ-017 If load AND ready: pend <= data and pend_valid <= 1. If load AND NOT ready: the load is dropped and no state changes.
REQ-018 At a frame boundary with pend_valid=1: disp <= pend and pend_valid <= 0. The display never changes mid-frame (no tearing).
REQ-019 Simultaneous load and frame boundary with pend_valid=1: the transfer occurs, the load is dropped, and ready rises on the following cycle.
REQ-020 Simultaneous load and frame boundary with pend_valid=0: the load is captured into pend; there is no transfer until the next boundary.
REQ-021 digit SHALL equal disp[4*idx+3 : 4*idx]; it is combinational from registers and changes on the edge that updates idx.
REQ-022 Invalid BCD: a slot nibble > 9 SHALL be blanked regardless of lzb_en.
REQ-023 LZB: with lzb_en=1, slot i (i = 3,2,1) SHALL be blanked when nibble i and all higher nibbles are 0. Slot 0 is never blanked by LZB.
REQ-024 blank=1 SHALL force an=4'b1111. Otherwise an = all ones except bit idx = 0.
REQ-025 lzb_en is sampled combinationally; a change takes effect in the current slot.

Reset
REQ-026 While rst is high, the following SHALL hold immediately, independent of clk:
- cnt=0, idx=0
- disp=0, pend=0, pend_valid=0
- ready=1, frame_done=0
- digit=4'h0, blank=0, an=4'b1110
REQ-027 A reset mid-frame or with a load pending SHALL discard the pending data. Scan restarts at slot 0 with a full DIV-cycle slot after rst falls.

Verification (DIV=4)
REQ-028 Assert rst mid-scan with pend_valid=1 -> same cycle: an=1110, digit=0, ready=1, frame_done=0. After release, the first tick occurs 4 cycles later.
REQ-029 Load 16'h1234, lzb_en=0, and wait for the transfer -> per slot, 4 cycles each:
- slot 0: an=1110, digit=4
- slot 1: an=1101, digit=3
- slot 2: an=1011, digit=2
- slot 3: an=0111, digit=1
- frame_done pulses every 16 cycles.
REQ-030 Load 16'h1111, then load 16'h2222 on the next cycle -> the second load is dropped; ready=0 until the boundary; the display shows 1111 and ready=1 the cycle after the boundary.
REQ-031 Data 16'h0050 -> with lzb_en=1: slots 3 and 2 give an=1111, blank=1; slot 1 shows 5; slot 0 shows 0. With lzb_en=0: all four slots are shown.
REQ-032 Data 16'h00A0, lzb_en=0 -> slot 1 is blanked (an=1111, blank=1); the other slots are shown normally.
REQ-033 Load asserted on the frame-boundary cycle with pend_valid=1 -> disp takes the old pend, the new data is dropped, and ready=1 on the next cycle.
